ent_encoder_arbiter: RTL and testbench

- Shares one EN-T multi-bit encoder pipeline (8-bit in, 9-bit out, fixed 2-cycle latency, no stall input) between NUM_REQ operand loaders.
- Uses round-robin arbitration and tags each issued operand with its requester ID.
- Issues to the encoder only when result-buffer space is guaranteed, using credits.
- Returns tagged encoded operands through a valid/ready output FIFO toward tensorcore local RF.

---
 rtl/ent_arb_pkg.sv | 15 +
 rtl/ent_rr_arbiter.sv | 19 +
 rtl/ent_encoder_arbiter.sv | 110 +++++++++++
 tb/tb_ent_encoder_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ent_arb_pkg.sv
// ent_arb_pkg: shared widths and tag/result types for the EN-T encoder arbiter
package ent_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int ID_W = $clog2(DEF_NUM_REQ);
  localparam int ENC_W = DEF_WIDTH + 1;
  typedef struct packed {
    logic vld;
    logic [ID_W-1:0] id;
  } ent_tag_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ENC_W-1:0] data;
  } ent_res_t;
endpackage

// File: rtl/ent_rr_arbiter.sv
// ent_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module ent_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  // scan from the farthest offset down so the nearest requester at or after ptr wins
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[ptr + IW'(k)]) idx = ptr + IW'(k);
    gnt = (en && |req) ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/ent_encoder_arbiter.sv
// ent_encoder_arbiter: credit-gated round-robin sharing of one EN-T encoder; optional ENT_ARB_STALL_CNT_EN adds a credit-stall counter
module ent_encoder_arbiter
  import ent_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ENC_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           enc_multiplicand,
  output logic                       enc_valid,
  input  logic [WIDTH:0]             enc_result,
  input  logic                       enc_result_valid,
  output logic                       out_valid,
  output logic [WIDTH:0]             out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  input  logic                       out_ready,
  output logic                       tag_err,
  output logic [15:0]                stall_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = $clog2(ENC_LAT + 2);
  logic [IW-1:0] rr_ptr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [LW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  ent_tag_t tag_q [ENC_LAT+1];
  ent_res_t mem [FIFO_DEPTH];
  logic can_issue, issue, push, pop, full;
  assign can_issue = 32'(inflight) + 32'(fifo_cnt) < 32'(FIFO_DEPTH);
  assign issue = |gnt;
  assign full = fifo_cnt == CW'(FIFO_DEPTH);
  assign push = enc_result_valid && !full;
  assign out_valid = fifo_cnt != '0;
  assign pop = out_valid && out_ready;
  assign out_data = mem[rd_ptr].data;
  assign out_id = mem[rd_ptr].id;
  assign req_ready = gnt;
  ent_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .en (can_issue && rst_n),
    .gnt(gnt),
    .idx(gidx)
  );
  // issue register toward the encoder and round-robin pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      enc_valid <= 1'b0;
      enc_multiplicand <= '0;
    end else begin
      enc_valid <= issue;
      if (issue) begin
        rr_ptr <= gidx + IW'(1);
        enc_multiplicand <= req_data[32'(gidx)*WIDTH +: WIDTH];
      end
    end
  end
  // tag shift register aligned with encoder output; sticky error on any valid mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ENC_LAT; i++) tag_q[i] <= '0;
      tag_err <= 1'b0;
    end else begin
      tag_q[0] <= {issue, gidx};
      for (int i = 1; i <= ENC_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (enc_result_valid != tag_q[ENC_LAT].vld) tag_err <= 1'b1;
    end
  end
  // credit counters and result FIFO; inflight is guarded against a spurious result underflowing it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      inflight <= inflight + LW'(issue) - LW'(enc_result_valid && inflight != '0);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) begin
        mem[wr_ptr] <= '{id: tag_q[ENC_LAT].id, data: enc_result};
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  // a result arriving on a full FIFO means the credit scheme was violated
  always_ff @(posedge clk) begin
    if (rst_n && enc_result_valid) assert (!full);
  end
`ifdef ENT_ARB_STALL_CNT_EN
  // saturating count of cycles where a request waits only for credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (|req_valid && !can_issue && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ent_encoder_arbiter.sv
// tb_ent_encoder_arbiter: scoreboard bench with a 2-cycle +1 stub encoder
module tb_ent_encoder_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ready;
  logic [7:0] enc_multiplicand;
  logic enc_valid;
  logic [8:0] enc_result;
  logic enc_result_valid;
  logic out_valid;
  logic [8:0] out_data;
  logic [1:0] out_id;
  logic out_ready = 1'b0;
  logic tag_err;
  logic [15:0] stall_cnt;
  logic s1_v, s2_v, force_rv = 1'b0;
  logic [8:0] s1_d, s2_d;
  int n_chk = 0, n_pass = 0;
  logic mon_en = 1'b0;
  int occ = 0, ptr = 0, n_pop = 0, n_gnt = 0;
  logic [10:0] sb [$];

  always #5 clk = ~clk;

  ent_encoder_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_multiplicand(enc_multiplicand), .enc_valid(enc_valid),
    .enc_result(enc_result), .enc_result_valid(enc_result_valid), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready), .tag_err(tag_err),
    .stall_cnt(stall_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
    end else begin
      s1_v <= enc_valid; s1_d <= {1'b0, enc_multiplicand} + 9'd1;
      s2_v <= s1_v; s2_d <= s1_d;
    end
  end
  assign enc_result_valid = s2_v | force_rv;
  assign enc_result = s2_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    logic [3:0] eg;
    int gi;
    logic [10:0] e;
    if (!rst_n) begin
      sb.delete(); occ = 0; ptr = 0;
    end else if (mon_en) begin
      eg = '0; gi = 0;
      if (occ < 4)
        for (int k = 3; k >= 0; k--)
          if (req_valid[(ptr + k) % 4]) begin gi = (ptr + k) % 4; eg = 4'b0001 << gi; end
      check("grant", req_ready, eg);
      if (eg != 0) begin
        sb.push_back({2'(gi), {1'b0, req_data[gi*8 +: 8]} + 9'd1});
        ptr = (gi + 1) % 4; occ++; n_gnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", out_valid, 0);
        else begin
          e = sb.pop_front();
          check("out_id", out_id, e[10:9]);
          check("out_data", out_data, e[8:0]);
        end
        occ--; n_pop++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin cyc(1); t++; end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, g0, n, t;
    logic [15:0] s0;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_enc_valid", enc_valid, 0);
    check("rst_enc_mult", enc_multiplicand, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_stall", stall_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;

    out_ready = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'h05;
    @(negedge clk); check("single_ready", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    lat = 1;
    while (!out_valid && lat < 20) begin cyc(1); lat++; end
    check("single_lat", lat, 4);
    check("single_data", out_data, 9'h006);
    check("single_id", out_id, 0);
    drain();

    g0 = n_gnt; req_valid = 4'hF;
    for (int i = 0; i < 24; i++) begin req_data = $urandom; cyc(1); end
    req_valid = '0;
    check("rr_tput", 32'(n_gnt - g0 >= 16), 1);
    drain();

    out_ready = 1'b0; g0 = n_gnt; req_valid = 4'hF; req_data = 32'hA1B2C3D4;
    cyc(8);
    check("bp_grants", n_gnt - g0, 4);
    check("bp_ready", req_ready, 0);
    s0 = stall_cnt;
    cyc(5);
`ifdef ENT_ARB_STALL_CNT_EN
    check("bp_stall", stall_cnt, s0 + 16'd5);
`else
    check("bp_stall", stall_cnt, 0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin req_data = $urandom; cyc(1); end
    req_valid = '0;
    drain();
    check("bp_lost", n_pop, n_gnt);

    req_valid = 4'b0100; n = 0; t = 0;
    while (n < 20 && t < 400) begin
      req_data[23:16] = 8'(n * 7 + 3);
      @(negedge clk); if (req_ready[2]) n++;
      @(posedge clk); #1 out_ready = ~out_ready; t++;
    end
    req_valid = '0; out_ready = 1'b1;
    check("wrap_n", n, 20);
    drain();
    check("wrap_lost", n_pop, n_gnt);

    mon_en = 1'b0; out_ready = 1'b0;
    force_rv = 1'b1; cyc(1); force_rv = 1'b0;
    check("perr_set", tag_err, 1);
    cyc(3);
    check("perr_sticky", tag_err, 1);
    check("perr_push", out_valid, 1);
    rst_n = 1'b0; #1;
    check("perr_clr", tag_err, 0);
    check("perr_out_valid", out_valid, 0);
    check("perr_stall", stall_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;

    req_valid = 4'hF; req_data = 32'h11223344;
    cyc(5);
    rst_n = 1'b0; #1;
    check("mid_ready", req_ready, 0);
    check("mid_enc_valid", enc_valid, 0);
    check("mid_enc_mult", enc_multiplicand, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_out_id", out_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); check("mid_rr0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
